serial_frame_register: RTL and testbench

Parametrised serial-to-parallel capture register with chip-select framing, driven by an externally supplied, slow serial clock that is oversampled in the fabric clock domain. It synchronises `sclk`, `cs_n` and `data_in`, detects `sclk` rising edges and shifts up to `WIDTH` bits per frame in a selectable bit order. It commits the word to `data_out` only when a frame closes with exactly `WIDTH` bits, and reports malformed frames. It sits between off-chip configuration masters and control registers in the RFSoC controller fabric.

---
 rtl/serial_frame_register_if.sv | 54 +++++
 rtl/serial_frame_register.sv | 182 ++++++++++++++++++
 tb/tb_serial_frame_register.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_register_if.sv
// ---------------------------------------------------------------------------
// serial_frame_register_if
//
// Purpose: groups the serial framing pins and the parallel result signals
//          of serial_frame_register into a single bundle.
//
// Signals:
//   sclk, cs_n, data_in : serial side, driven by the off-chip master
//   data_out [WIDTH]    : last committed parallel word
//   data_valid          : one-cycle pulse when data_out updates
//   frame_error         : one-cycle pulse when a frame closes with a bad count
//   busy                : high while a frame is being shifted in
//   sdo                 : readback serial data (only with SERIAL_READBACK_EN)
//
// Modports:
//   master : the side that drives the serial pins and observes the results
//   slave  : the capture register itself
//
// Configuration macro: SERIAL_READBACK_EN adds the sdo signal.
// ---------------------------------------------------------------------------
interface serial_frame_register_if #(
  parameter int WIDTH = 32
);
  logic             sclk;
  logic             cs_n;
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_error;
  logic             busy;
`ifdef SERIAL_READBACK_EN
  logic             sdo;

  modport master (
    output sclk, cs_n, data_in,
    input  data_out, data_valid, frame_error, busy, sdo
  );

  modport slave (
    input  sclk, cs_n, data_in,
    output data_out, data_valid, frame_error, busy, sdo
  );
`else
  modport master (
    output sclk, cs_n, data_in,
    input  data_out, data_valid, frame_error, busy
  );

  modport slave (
    input  sclk, cs_n, data_in,
    output data_out, data_valid, frame_error, busy
  );
`endif
endinterface

// File: rtl/serial_frame_register.sv
// ---------------------------------------------------------------------------
// serial_frame_register
//
// Purpose: serial-to-parallel capture register with chip-select framing.
//          sclk, cs_n and data_in are asynchronous to clk; each is passed
//          through its own synchroniser chain, sclk rising edges are detected
//          in the clk domain and up to WIDTH bits are shifted per frame.
//          A frame that closes with exactly WIDTH bits is committed to
//          data_out; any other count raises a frame_error pulse instead.
//
// Parameters:
//   WIDTH       : frame / word length in bits (>= 2)
//   LSB_FIRST   : 1 = first received bit lands in bit 0, 0 = MSB first
//   SYNC_STAGES : synchroniser depth per input (>= 2)
//
// Ports:
//   clk   : fabric clock, the only clock
//   reset : asynchronous active-high reset
//   bus   : serial_frame_register_if slave modport (sclk, cs_n, data_in in;
//           data_out, data_valid, frame_error, busy [, sdo] out)
//
// Configuration macro: SERIAL_READBACK_EN
//   When defined, the previous data_out is shifted out on bus.sdo during
//   the next frame, advancing on every sclk falling edge.
// ---------------------------------------------------------------------------
module serial_frame_register #(
  parameter int WIDTH       = 32,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_frame_register_if.slave bus
);

  // Counter is wide enough to hold WIDTH+1, the saturating overrun code.
  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVR  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csnSync;
  logic [SYNC_STAGES-1:0] r_dinSync;
  logic                   r_sclkPrev;

  logic                   w_sclk;
  logic                   w_csn;
  logic                   w_din;
  logic                   w_rise;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cntNext;
  logic [WIDTH-1:0]       r_shreg;
  logic [WIDTH-1:0]       w_shregNext;
  logic [WIDTH-1:0]       r_dataOut;
  logic                   r_dataValid;
  logic                   r_frameError;
  logic                   r_busy;

`ifdef SERIAL_READBACK_EN
  localparam int          RD_IDX = (LSB_FIRST != 0) ? 0 : WIDTH - 1;
  logic                   w_fall;
  logic [WIDTH-1:0]       r_rdbk;
`endif

  // Synchroniser chains; cs_n idles high so its chain resets to ones to
  // avoid opening a spurious frame as reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclkSync <= '0;
      r_csnSync  <= '1;
      r_dinSync  <= '0;
      r_sclkPrev <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], bus.sclk};
      r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], bus.cs_n};
      r_dinSync  <= {r_dinSync[SYNC_STAGES-2:0], bus.data_in};
      r_sclkPrev <= w_sclk;
    end
  end

  assign w_sclk = r_sclkSync[SYNC_STAGES-1];
  assign w_csn  = r_csnSync[SYNC_STAGES-1];
  assign w_din  = r_dinSync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclkPrev;
`ifdef SERIAL_READBACK_EN
  assign w_fall = ~w_sclk & r_sclkPrev;
`endif

  // Effect of a possible rise in this cycle. The frame-close decision uses
  // these values so that a rise coincident with cs_n going high still counts.
  always_comb begin
    w_cntNext   = r_cnt;
    w_shregNext = r_shreg;
    if (w_rise) begin
      if (r_cnt < CNT_FULL) begin
        if (LSB_FIRST != 0) begin
          w_shregNext = {w_din, r_shreg[WIDTH-1:1]};
        end else begin
          w_shregNext = {r_shreg[WIDTH-2:0], w_din};
        end
      end
      if (r_cnt != CNT_OVR) begin
        w_cntNext = r_cnt + CNT_ONE;
      end
    end
  end

  // Framing FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_frameError <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SERIAL_READBACK_EN
      r_rdbk       <= '0;
`endif
    end else begin
      r_dataValid  <= 1'b0;
      r_frameError <= 1'b0;
      case (r_state)
        IDLE: begin
          // sclk edges are deliberately ignored here, even one arriving
          // together with the cs_n fall.
          if (!w_csn) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
`ifdef SERIAL_READBACK_EN
            r_rdbk  <= r_dataOut;
`endif
          end
        end
        SHIFT: begin
          r_shreg <= w_shregNext;
          r_cnt   <= w_cntNext;
`ifdef SERIAL_READBACK_EN
          // Zeros shift in behind the data, so falls past the last bit
          // present 0.
          if (w_fall) begin
            if (LSB_FIRST != 0) begin
              r_rdbk <= {1'b0, r_rdbk[WIDTH-1:1]};
            end else begin
              r_rdbk <= {r_rdbk[WIDTH-2:0], 1'b0};
            end
          end
`endif
          if (w_csn) begin
            if (w_cntNext == CNT_FULL) begin
              r_dataOut   <= w_shregNext;
              r_dataValid <= 1'b1;
            end else begin
              r_frameError <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = r_dataOut;
  assign bus.data_valid  = r_dataValid;
  assign bus.frame_error = r_frameError;
  assign bus.busy        = r_busy;
`ifdef SERIAL_READBACK_EN
  // busy mirrors the SHIFT state, which keeps sdo at 0 while idle.
  assign bus.sdo         = r_busy & r_rdbk[RD_IDX];
`endif

endmodule

// File: tb/tb_serial_frame_register.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_register
//
// Purpose: self-checking bench for serial_frame_register. Two instances
//          share one serial stream: dutA (WIDTH 32, LSB first) and
//          dutB (WIDTH 8, MSB first). Every frame is described as a list of
//          bits; the expected outcome for each instance follows from the
//          list length and bit order alone.
//
// Configuration macro: SERIAL_READBACK_EN enables the sdo readback checks.
// ---------------------------------------------------------------------------
module tb_serial_frame_register;

  typedef logic bitq_t[$];

  logic clk = 1'b0;
  logic reset;
  logic sclk;
  logic cs_n;
  logic data_in;

  int vectors     = 0;
  int miscompares = 0;

  // Expected committed words.
  logic [31:0] expA;
  logic [7:0]  expB;

  // Strobe counters filled by the monitor.
  int dvA = 0, feA = 0, dvB = 0, feB = 0, bothA = 0, bothB = 0;

`ifdef SERIAL_READBACK_EN
  logic sdoA[$];
  logic sdoB[$];
`endif

  serial_frame_register_if #(.WIDTH(32)) busA ();
  serial_frame_register_if #(.WIDTH(8))  busB ();

  assign busA.sclk    = sclk;
  assign busA.cs_n    = cs_n;
  assign busA.data_in = data_in;
  assign busB.sclk    = sclk;
  assign busB.cs_n    = cs_n;
  assign busB.data_in = data_in;

  serial_frame_register #(.WIDTH(32), .LSB_FIRST(1), .SYNC_STAGES(2)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  serial_frame_register #(.WIDTH(8), .LSB_FIRST(0), .SYNC_STAGES(2)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  always #5 clk = ~clk;

  // Count strobes away from the active edge.
  always @(negedge clk) begin
    if (busA.data_valid)  dvA++;
    if (busA.frame_error) feA++;
    if (busB.data_valid)  dvB++;
    if (busB.frame_error) feB++;
    if (busA.data_valid && busA.frame_error) bothA++;
    if (busB.data_valid && busB.frame_error) bothB++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: word built from the received bit list in the given order.
  function automatic logic [31:0] assemble(input bitq_t bits, input int width, input bit lsbFirst);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < width; i++) begin
      if (lsbFirst) w[i] = bits[i];
      else          w[width-1-i] = bits[i];
    end
    return w;
  endfunction

  function automatic bitq_t lsbBits(input logic [31:0] word, input int n);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back((i < 32) ? word[i] : 1'($urandom));
    return q;
  endfunction

  function automatic bitq_t msbBits(input logic [31:0] word, input int width);
    bitq_t q;
    for (int i = 0; i < width; i++) q.push_back(word[width-1-i]);
    return q;
  endfunction

  task automatic driveBit(input logic b);
    data_in = b;
    waitCycles(2);
`ifdef SERIAL_READBACK_EN
    sdoA.push_back(busA.sdo);
    sdoB.push_back(busB.sdo);
`endif
    sclk = 1'b1;
    waitCycles(4);
    sclk = 1'b0;
    waitCycles(2);
  endtask

  // One complete frame with timing and result checks for both instances.
  task automatic runFrame(input string name, input bitq_t bits, input bit coincident, input int tail);
    int  n;
    int  dvA0, feA0, dvB0, feB0;
    logic okA, okB;
    n = bits.size();
    dvA0 = dvA; feA0 = feA; dvB0 = dvB; feB0 = feB;

    cs_n = 1'b0;
    waitCycles(2);
    vectors++;
    if (busA.busy !== 1'b0 || busB.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s busy_early: A=%b B=%b, required 0", name, busA.busy, busB.busy);
    end
    waitCycles(1);
    vectors++;
    if (busA.busy !== 1'b1 || busB.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s busy_rise: A=%b B=%b, required 1", name, busA.busy, busB.busy);
    end
    waitCycles(1);

    for (int i = 0; i < n; i++) begin
      if (coincident && i == n - 1) begin
        data_in = bits[i];
        waitCycles(2);
`ifdef SERIAL_READBACK_EN
        sdoA.push_back(busA.sdo);
        sdoB.push_back(busB.sdo);
`endif
        sclk = 1'b1;
        cs_n = 1'b1;
      end else begin
        driveBit(bits[i]);
      end
    end
    if (!(coincident && n > 0)) cs_n = 1'b1;

    okA = (n == 32);
    okB = (n == 8);
    if (okA) expA = assemble(bits, 32, 1'b1);
    if (okB) expB = 8'(assemble(bits, 8, 1'b0));

    waitCycles(2);
    vectors++;
    if ((busA.data_valid | busA.frame_error | busB.data_valid | busB.frame_error) !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s strobe_early: A dv/fe=%b%b B dv/fe=%b%b, required 00", name,
               busA.data_valid, busA.frame_error, busB.data_valid, busB.frame_error);
    end
    waitCycles(1);
    vectors++;
    if (busA.data_valid !== okA || busA.frame_error !== !okA) begin
      miscompares++;
      $display("[TB] FAIL %s strobeA: dv/fe=%b%b, required %b%b", name,
               busA.data_valid, busA.frame_error, okA, !okA);
    end
    vectors++;
    if (busA.data_out !== expA) begin
      miscompares++;
      $display("[TB] FAIL %s data_outA: got %h, required %h", name, busA.data_out, expA);
    end
    vectors++;
    if (busB.data_valid !== okB || busB.frame_error !== !okB) begin
      miscompares++;
      $display("[TB] FAIL %s strobeB: dv/fe=%b%b, required %b%b", name,
               busB.data_valid, busB.frame_error, okB, !okB);
    end
    vectors++;
    if (busB.data_out !== expB) begin
      miscompares++;
      $display("[TB] FAIL %s data_outB: got %h, required %h", name, busB.data_out, expB);
    end
    vectors++;
    if (busA.busy !== 1'b0 || busB.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s busy_fall: A=%b B=%b, required 0", name, busA.busy, busB.busy);
    end

    @(negedge clk);
    #1;
    vectors++;
    if ((dvA - dvA0) != int'(okA) || (feA - feA0) != int'(!okA) ||
        (dvB - dvB0) != int'(okB) || (feB - feB0) != int'(!okB)) begin
      miscompares++;
      $display("[TB] FAIL %s pulse_count: A dv=%0d fe=%0d B dv=%0d fe=%0d, required A %0d/%0d B %0d/%0d",
               name, dvA - dvA0, feA - feA0, dvB - dvB0, feB - feB0,
               int'(okA), int'(!okA), int'(okB), int'(!okB));
    end
    sclk = 1'b0;
    if (tail > 0) waitCycles(tail);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    data_in = 1'b0;
    expA    = '0;
    expB    = '0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    vectors++;
    if (busA.data_out !== 32'h0 || busA.data_valid !== 1'b0 ||
        busA.frame_error !== 1'b0 || busA.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_A: data_out=%h dv=%b fe=%b busy=%b, required 0", busA.data_out,
               busA.data_valid, busA.frame_error, busA.busy);
    end
    vectors++;
    if (busB.data_out !== 8'h0 || busB.data_valid !== 1'b0 ||
        busB.frame_error !== 1'b0 || busB.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_B: data_out=%h dv=%b fe=%b busy=%b, required 0", busB.data_out,
               busB.data_valid, busB.frame_error, busB.busy);
    end
`ifdef SERIAL_READBACK_EN
    vectors++;
    if (busA.sdo !== 1'b0 || busB.sdo !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_sdo: A=%b B=%b, required 0", busA.sdo, busB.sdo);
    end
`endif
  endtask

  task automatic test_lsb_first();
    runFrame("lsb32", lsbBits(32'hA5C3_0F81, 32), 1'b0, 4);
  endtask

  task automatic test_reset_mid_frame();
    int dvA0, feA0, dvB0, feB0;
    dvA0 = dvA; feA0 = feA; dvB0 = dvB; feB0 = feB;
    cs_n = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 10; i++) driveBit(1'($urandom));
    reset = 1'b1;
    waitCycles(1);
    cs_n = 1'b1;
    sclk = 1'b0;
    waitCycles(2);
    reset = 1'b0;
    expA  = '0;
    expB  = '0;
    waitCycles(8);
    vectors++;
    if (busA.data_out !== 32'h0 || busB.data_out !== 8'h0 ||
        busA.busy !== 1'b0 || busB.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: A=%h B=%h busyA=%b busyB=%b, required 0", busA.data_out,
               busB.data_out, busA.busy, busB.busy);
    end
    vectors++;
    if (dvA != dvA0 || feA != feA0 || dvB != dvB0 || feB != feB0) begin
      miscompares++;
      $display("[TB] FAIL midreset_strobe: new pulses A %0d/%0d B %0d/%0d, required none",
               dvA - dvA0, feA - feA0, dvB - dvB0, feB - feB0);
    end
  endtask

  task automatic test_msb_first();
    runFrame("msb8", msbBits(32'h0000_003C, 8), 1'b0, 4);
  endtask

  task automatic test_bad_lengths();
    runFrame("len32_seed", lsbBits(32'h1234_5678, 32), 1'b0, 4);
    runFrame("len31", lsbBits($urandom, 31), 1'b0, 4);
    runFrame("len33", lsbBits($urandom, 33), 1'b0, 4);
    runFrame("len0", lsbBits(32'h0, 0), 1'b0, 4);
    vectors++;
    if (busA.data_out !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL bad_len_hold: got %h, required 12345678", busA.data_out);
    end
  endtask

  task automatic test_coincident();
    runFrame("coinc32", lsbBits($urandom, 32), 1'b1, 4);
    runFrame("coinc31", lsbBits($urandom, 31), 1'b1, 4);
    runFrame("coinc8", msbBits($urandom, 8), 1'b1, 4);
  endtask

  task automatic test_random();
    int lens[8] = '{0, 7, 8, 9, 31, 32, 32, 33};
    for (int k = 0; k < 10; k++) begin
      runFrame($sformatf("rand%0d", k), lsbBits($urandom, lens[$urandom_range(0, 7)]),
               1'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    runFrame("b2b0", lsbBits($urandom, 32), 1'b0, 0);
    runFrame("b2b1", lsbBits($urandom, 32), 1'b1, 0);
    runFrame("b2b2", msbBits($urandom, 8), 1'b0, 4);
  endtask

`ifdef SERIAL_READBACK_EN
  task automatic test_readback();
    logic [7:0] oldB;
    bitq_t      qa;
    bitq_t      qb;
    int         extra;
    runFrame("rb_seed", lsbBits(32'hDEAD_BEEF, 32), 1'b0, 4);
    oldB = expB;
    sdoA.delete();
    sdoB.delete();
    runFrame("rb_frame", lsbBits(32'h0000_0001, 32), 1'b0, 4);
    qa = sdoA;
    qb = sdoB;
    vectors++;
    if (assemble(qa, 32, 1'b1) !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL readback_A: got %h, required deadbeef", assemble(qa, 32, 1'b1));
    end
    extra = 0;
    for (int i = 8; i < qb.size(); i++) if (qb[i] !== 1'b0) extra++;
    vectors++;
    if (8'(assemble(qb, 8, 1'b0)) !== oldB || extra != 0) begin
      miscompares++;
      $display("[TB] FAIL readback_B: got %h with %0d trailing ones, required %h with 0",
               8'(assemble(qb, 8, 1'b0)), extra, oldB);
    end
    vectors++;
    if (busA.sdo !== 1'b0 || busB.sdo !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL readback_idle: A=%b B=%b, required 0", busA.sdo, busB.sdo);
    end
  endtask
`endif

  task automatic test_exclusion();
    vectors++;
    if (bothA != 0 || bothB != 0) begin
      miscompares++;
      $display("[TB] FAIL exclusion: overlapping strobes A=%0d B=%0d, required 0", bothA, bothB);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_reset_mid_frame();
    test_msb_first();
    test_bad_lengths();
    test_coincident();
    test_random();
    test_back_to_back();
`ifdef SERIAL_READBACK_EN
    test_readback();
`endif
    test_exclusion();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
